// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : Pipelined WIDTH-bit adder/subtractor. The add is split into
//            STAGES slices of SLICE = WIDTH/STAGES bits; the inter-slice carry
//            is registered so one operation enters per cycle. Valid/ready
//            handshakes on both sides; a single global advance moves the
//            whole pipe, so a stalled output freezes every stage.
// Ports    : clk, rst_n (async, active-low)
//            A, B, CI, SUB, IN_VALID -> IN_READY        (input side)
//            SUM, CO, OFL, OUT_VALID <- OUT_READY       (output side)
//            SUB=0: SUM = A+B+CI ; SUB=1: SUM = A-B (CI ignored, CO=1 means
//            no borrow). OFL is two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OFL,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;

    // Per-stage registers. Each stage keeps the (inverted-if-subtract)
    // operands so later stages can pick up their own slice, plus the sum
    // bits completed so far and the carry out of the slice just added.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             ofl_q;
    logic             ofl_d;

    logic             adv;

    // Inputs seen by the stage currently being evaluated in the loop below.
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [SLICE:0]   part;

    // The pipe only moves as a whole; bubbles are never squeezed out.
    assign adv = !valid_q[LAST] || OUT_READY;

    always_comb begin
        // Stage 0 is fed from the ports; subtract is A + ~B + 1.
        a_in  = A;
        b_in  = SUB ? ~B : B;
        c_in  = SUB ? 1'b1 : CI;
        s_in  = '0;
        v_in  = IN_VALID;
        part  = '0;
        ofl_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_in[k*SLICE +: SLICE]}
                 + {1'b0, b_in[k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, c_in};
            sum_d[k]                  = s_in;
            sum_d[k][k*SLICE +: SLICE] = part[SLICE-1:0];
            carry_d[k]                = part[SLICE];
            a_d[k]                    = a_in;
            b_d[k]                    = b_in;
            valid_d[k]                = v_in;
            // Overflow is resolved where the MSB slice is added: operands of
            // equal sign giving a result of the other sign.
            if (k == LAST) begin
                ofl_d = (a_in[MSB] == b_in[MSB]) && (sum_d[k][MSB] != a_in[MSB]);
            end
            // Next stage reads this stage's registers.
            a_in = a_q[k];
            b_in = b_q[k];
            s_in = sum_q[k];
            c_in = carry_q[k];
            v_in = valid_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ofl_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            ofl_q <= ofl_d;
        end
    end

    assign IN_READY  = adv;
    assign SUM       = sum_q[LAST];
    assign CO        = carry_q[LAST];
    assign OFL       = ofl_q;
    assign OUT_VALID = valid_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Self-checking bench for pipe_adder. Three instances are driven
//            from shared stimulus: 16-bit/4 stages (main), 16-bit/1 stage and
//            32-bit/8 stages. Expected results come from an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    localparam int WC [3] = '{16, 16, 32};
    localparam int SC [3] = '{4, 1, 8};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic [15:0] sum0, sum1;
    logic [31:0] sum2;
    logic        co0, co1, co2, ofl0, ofl1, ofl2;
    logic        ov0, ov1, ov2, ir0, ir1, ir2;

    logic [31:0] r_sum [3];
    logic        r_co  [3];
    logic        r_ofl [3];
    logic        r_ov  [3];
    logic        r_ir  [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Expected-result ring buffers, one per instance.
    logic [31:0] e_sum [3][16];
    logic        e_co  [3][16];
    logic        e_ofl [3][16];
    int          e_t   [3][16];
    int          wr    [3];
    int          rd    [3];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .A(a_in[15:0]), .B(b_in[15:0]), .CI(ci), .SUB(sub),
        .IN_VALID(in_valid), .IN_READY(ir0), .SUM(sum0), .CO(co0), .OFL(ofl0),
        .OUT_VALID(ov0), .OUT_READY(out_ready));

    pipe_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a_in[15:0]), .B(b_in[15:0]), .CI(ci), .SUB(sub),
        .IN_VALID(in_valid), .IN_READY(ir1), .SUM(sum1), .CO(co1), .OFL(ofl1),
        .OUT_VALID(ov1), .OUT_READY(out_ready));

    pipe_adder #(.WIDTH(32), .STAGES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .CI(ci), .SUB(sub),
        .IN_VALID(in_valid), .IN_READY(ir2), .SUM(sum2), .CO(co2), .OFL(ofl2),
        .OUT_VALID(ov2), .OUT_READY(out_ready));

    always_comb begin
        r_sum[0] = {16'h0, sum0}; r_co[0] = co0; r_ofl[0] = ofl0; r_ov[0] = ov0; r_ir[0] = ir0;
        r_sum[1] = {16'h0, sum1}; r_co[1] = co1; r_ofl[1] = ofl1; r_ov[1] = ov1; r_ir[1] = ir1;
        r_sum[2] = sum2;          r_co[2] = co2; r_ofl[2] = ofl2; r_ov[2] = ov2; r_ir[2] = ir2;
    end

    // Reference: plain integer arithmetic on w-bit operands. Returns {ofl, co, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        longint m, ua, ub, full, sa, sb, sr, sm;
        logic   co, of;
        m  = longint'(1) << w;
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            full = ua - ub;
            co   = (ua >= ub);
            sr   = sa - sb;
        end else begin
            full = ua + ub + longint'(c);
            co   = (full >= m);
            sr   = sa + sb + longint'(c);
        end
        sm = ((full % m) + m) % m;
        of = (sr < -(m / 2)) || (sr >= m / 2);
        return {of, co, 32'(sm)};
    endfunction

    task automatic push_exp(input int d, input logic [33:0] m, input int t);
        e_sum[d][wr[d] % 16] = m[31:0];
        e_co[d][wr[d] % 16]  = m[32];
        e_ofl[d][wr[d] % 16] = m[33];
        e_t[d][wr[d] % 16]   = t;
        wr[d]++;
    endtask

    task automatic clear_sb;
        for (int d = 0; d < 3; d++) begin
            wr[d] = 0;
            rd[d] = 0;
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (ov0 !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        n_checks++; if (sum0 !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum0); end
        n_checks++; if (co0 !== 1'b0 || ofl0 !== 1'b0) begin n_fail++; $display("FAIL reset_co_ofl: got %b%b want 00", co0, ofl0); end
        n_checks++; if (ir0 !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
        n_checks++; if (ov2 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_other_valid: got %b%b want 00", ov1, ov2); end
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
        logic [15:0] vb [5] = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0005};
        logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] xs [5] = '{16'h0100, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
        logic        xc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        xo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 5; v++) begin
            a_in = {16'h0, va[v]}; b_in = {16'h0, vb[v]}; ci = vc[v]; sub = vs[v];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ov0 !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid edge+%0d: got %b want 0", v, i, ov0); end
                @(posedge clk); #1;
            end
            n_checks++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency: got %b want 1", v, ov0); end
            n_checks++; if (sum0 !== xs[v]) begin n_fail++; $display("FAIL vec%0d_sum: got %h want %h", v, sum0, xs[v]); end
            n_checks++; if ({co0, ofl0} !== {xc[v], xo[v]}) begin n_fail++; $display("FAIL vec%0d_co_ofl: got %b%b want %b%b", v, co0, ofl0, xc[v], xo[v]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int sent = 0, got = 0, stall_cnt = 0, stalls = 0;
        bit first_seen = 0, pending = 0;
        clear_sb();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (sent < 6 && !pending) begin
                a_in = $urandom; b_in = $urandom; ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1; pending = 1;
            end else if (sent >= 6) begin
                in_valid = 1'b0;
            end
            out_ready = (stall_cnt > 0) ? 1'b0 : 1'b1;
            if (stall_cnt > 0) stall_cnt--;
            @(negedge clk);
            if (in_valid && ir0) begin
                push_exp(0, model(16, a_in, b_in, ci, sub), 0);
                sent++; pending = 0;
            end
            if (ov0) begin
                n_checks++;
                if (rd[0] == wr[0]) begin
                    n_fail++; $display("FAIL bp_extra_output: got sum %h with nothing expected", sum0);
                end else if (out_ready) begin
                    if ({ofl0, co0, sum0} !== {e_ofl[0][rd[0] % 16], e_co[0][rd[0] % 16], e_sum[0][rd[0] % 16][15:0]}) begin
                        n_fail++; $display("FAIL bp_result%0d: got %b%b_%h want %b%b_%h", got, ofl0, co0, sum0,
                                           e_ofl[0][rd[0] % 16], e_co[0][rd[0] % 16], e_sum[0][rd[0] % 16][15:0]);
                    end
                    rd[0]++; got++;
                    if (!first_seen) begin first_seen = 1; stall_cnt = 3; end
                end else begin
                    stalls++;
                    if (sum0 !== e_sum[0][rd[0] % 16][15:0]) begin
                        n_fail++; $display("FAIL bp_hold_sum: got %h want %h", sum0, e_sum[0][rd[0] % 16][15:0]);
                    end
                    n_checks++;
                    if (ir0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall: got %b want 0", ir0); end
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got); end
        n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stalls); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        logic [33:0] m;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom | 32'h1; b_in = $urandom; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", ov0); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", ov0); end
        n_checks++; if ({sum0, co0, ofl0} !== 18'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h %b %b want 0", sum0, co0, ofl0); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL mid_stale_output cycle %0d: got %b want 0", i, ov0); end
            @(posedge clk); #1;
        end
        a_in = 32'h1234; b_in = 32'h0F0F; ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
        m = model(16, a_in, b_in, ci, sub);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL mid_new_early edge+%0d: got %b want 0", i, ov0); end
            @(posedge clk); #1;
        end
        n_checks++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL mid_new_latency: got %b want 1", ov0); end
        n_checks++; if ({ofl0, co0, sum0} !== {m[33], m[32], m[15:0]}) begin
            n_fail++; $display("FAIL mid_new_result: got %b%b_%h want %b%b_%h", ofl0, co0, sum0, m[33], m[32], m[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int  edge_n = 0;
        bit  phase1;
        @(negedge clk); rst_n = 1'b0; #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_sb();
        for (int cyc = 0; cyc < 920; cyc++) begin
            phase1 = (cyc < 300);
            a_in = $urandom; b_in = $urandom;
            ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            if (cyc >= 900) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = phase1 ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (phase1) begin
                    n_checks++; if (r_ir[d] !== 1'b1) begin n_fail++; $display("FAIL rand_ready_hold dut%0d: got %b want 1", d, r_ir[d]); end
                end
                if (in_valid && r_ir[d]) push_exp(d, model(WC[d], a_in, b_in, ci, sub), edge_n + 1);
                if (r_ov[d] && out_ready) begin
                    n_checks++;
                    if (rd[d] == wr[d]) begin
                        n_fail++; $display("FAIL rand_extra dut%0d: got sum %h with nothing expected", d, r_sum[d]);
                    end else begin
                        if ({r_ofl[d], r_co[d], r_sum[d]} !== {e_ofl[d][rd[d] % 16], e_co[d][rd[d] % 16], e_sum[d][rd[d] % 16]}) begin
                            n_fail++; $display("FAIL rand_result dut%0d: got %b%b_%h want %b%b_%h", d, r_ofl[d], r_co[d], r_sum[d],
                                               e_ofl[d][rd[d] % 16], e_co[d][rd[d] % 16], e_sum[d][rd[d] % 16]);
                        end
                        if (phase1) begin
                            n_checks++;
                            if (edge_n - e_t[d][rd[d] % 16] != SC[d] - 1) begin
                                n_fail++; $display("FAIL rand_latency dut%0d: got %0d edges want %0d", d,
                                                   edge_n - e_t[d][rd[d] % 16] + 1, SC[d]);
                            end
                        end
                        rd[d]++;
                    end
                end
            end
            @(posedge clk); edge_n++; #1;
        end
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (rd[d] != wr[d]) begin n_fail++; $display("FAIL rand_drain dut%0d: got %0d outputs want %0d", d, rd[d], wr[d]); end
        end
    endtask

    initial begin
        clear_sb();
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
